// File: rtl/ofs_fim_pcie_ss_ib2sb_pkg.sv
// Shared types for the in-band to side-band TLP header converter.
// The header is always 256 bits wide, so it is a package constant.
package ofs_fim_pcie_ss_ib2sb_pkg;

    localparam int HDR_WIDTH = 256;
    localparam int HDR_BYTES = HDR_WIDTH / 8;

    typedef enum logic [1:0] {
        SOP   = 2'd0,
        MID   = 2'd1,
        FLUSH = 2'd2
    } t_ib2sb_state;

    // Header part of the hold register.
    // The payload remainder is sized by DATA_WIDTH, so it lives in the module.
    typedef struct packed {
        logic [HDR_WIDTH-1:0] hdr;
        logic                 vendor;
    } t_ib2sb_hold;

endpackage

// File: rtl/ofs_fim_pcie_ss_ib2sb.sv
// Moves the TLP header from the low 256 bits of the SOP beat onto tuser_vendor.
// The payload is shifted down by 256 bits, so each output beat straddles two input beats.
module ofs_fim_pcie_ss_ib2sb
    import ofs_fim_pcie_ss_ib2sb_pkg::*;
#(
    parameter int DATA_WIDTH = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic [DATA_WIDTH-1:0]   in_tdata,
    input  logic [DATA_WIDTH/8-1:0] in_tkeep,
    input  logic                    in_tlast,
    input  logic                    in_tuser_vendor,

    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic [DATA_WIDTH-1:0]   out_tdata,
    output logic [DATA_WIDTH/8-1:0] out_tkeep,
    output logic                    out_tlast,
    output logic [HDR_WIDTH:0]      out_tuser_vendor
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int HOLD_W     = DATA_WIDTH - HDR_WIDTH;
    localparam int HOLD_KW    = KEEP_WIDTH - HDR_BYTES;

    t_ib2sb_state            state_q, state_d;
    t_ib2sb_hold             hdr_q, hdr_d;
    logic                    first_q, first_d;
    logic [HOLD_W-1:0]       hold_data_q, hold_data_d;
    logic [HOLD_KW-1:0]      hold_keep_q, hold_keep_d;

    logic                    out_tvalid_q, out_tvalid_d;
    logic [DATA_WIDTH-1:0]   out_tdata_q, out_tdata_d;
    logic [KEEP_WIDTH-1:0]   out_tkeep_q, out_tkeep_d;
    logic                    out_tlast_q, out_tlast_d;
    logic [HDR_WIDTH:0]      out_tuser_q, out_tuser_d;

    logic                    out_slot_free;
    logic                    in_accept;
    logic                    upper_empty;

    assign out_slot_free = !out_tvalid_q || out_tready;
    assign in_tready     = out_slot_free && (state_q != FLUSH);
    assign in_accept     = in_tvalid && in_tready;
    assign upper_empty   = (in_tkeep[KEEP_WIDTH-1:HDR_BYTES] == '0);

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        first_d      = first_q;
        hold_data_d  = hold_data_q;
        hold_keep_d  = hold_keep_q;
        out_tvalid_d = out_tvalid_q;
        out_tdata_d  = out_tdata_q;
        out_tkeep_d  = out_tkeep_q;
        out_tlast_d  = out_tlast_q;
        out_tuser_d  = out_tuser_q;

        // A consumed beat leaves the slot empty unless something refills it below.
        if (out_slot_free) begin
            out_tvalid_d = 1'b0;
        end

        unique case (state_q)
            SOP: begin
                if (in_accept) begin
                    hdr_d.hdr    = in_tdata[HDR_WIDTH-1:0];
                    hdr_d.vendor = in_tuser_vendor;
                    first_d      = 1'b1;
                    hold_data_d  = in_tdata[DATA_WIDTH-1:HDR_WIDTH];
                    hold_keep_d  = in_tkeep[KEEP_WIDTH-1:HDR_BYTES];
                    state_d      = in_tlast ? FLUSH : MID;
                end
            end
            MID: begin
                if (in_accept) begin
                    out_tvalid_d = 1'b1;
                    out_tdata_d  = {in_tdata[HDR_WIDTH-1:0], hold_data_q};
                    out_tkeep_d  = {in_tkeep[HDR_BYTES-1:0], hold_keep_q};
                    out_tuser_d  = first_q ? {hdr_q.hdr, hdr_q.vendor} : '0;
                    first_d      = 1'b0;
                    hold_data_d  = in_tdata[DATA_WIDTH-1:HDR_WIDTH];
                    hold_keep_d  = in_tkeep[KEEP_WIDTH-1:HDR_BYTES];
                    out_tlast_d  = in_tlast && upper_empty;
                    if (in_tlast) begin
                        state_d = upper_empty ? SOP : FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Remainder of the last input beat; empty keep for header-only TLPs.
                if (out_slot_free) begin
                    out_tvalid_d = 1'b1;
                    out_tdata_d  = {{HDR_WIDTH{1'b0}}, hold_data_q};
                    out_tkeep_d  = {{HDR_BYTES{1'b0}}, hold_keep_q};
                    out_tuser_d  = first_q ? {hdr_q.hdr, hdr_q.vendor} : '0;
                    out_tlast_d  = 1'b1;
                    first_d      = 1'b0;
                    state_d      = SOP;
                end
            end
            default: begin
                state_d = SOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SOP;
            hdr_q        <= '0;
            first_q      <= 1'b0;
            hold_data_q  <= '0;
            hold_keep_q  <= '0;
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= '0;
            out_tkeep_q  <= '0;
            out_tlast_q  <= 1'b0;
            out_tuser_q  <= '0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            first_q      <= first_d;
            hold_data_q  <= hold_data_d;
            hold_keep_q  <= hold_keep_d;
            out_tvalid_q <= out_tvalid_d;
            out_tdata_q  <= out_tdata_d;
            out_tkeep_q  <= out_tkeep_d;
            out_tlast_q  <= out_tlast_d;
            out_tuser_q  <= out_tuser_d;
        end
    end

    assign out_tvalid       = out_tvalid_q;
    assign out_tdata        = out_tdata_q;
    assign out_tkeep        = out_tkeep_q;
    assign out_tlast        = out_tlast_q;
    assign out_tuser_vendor = out_tuser_q;

endmodule
